// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared data-memory port: registered one-hot grant,
// hold-counter bounded tenure with owner lock, per-requester mask and global enable.
module mem_port_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] lock_i,
  input  logic [NUM_REQ-1:0] mask_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_id_o,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam int HOLD_W = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                timeout_q, timeout_d;

  logic [NUM_REQ-1:0]  elig;
  logic [NUM_REQ-1:0]  others;
  logic                win_vld;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     scan_idx;
  logic [ID_W-1:0]     win_next;
  logic                owner_gone;
  logic                owner_expired;

  function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
    if (v >= HOLD_W'(MAX_HOLD)) begin
      return HOLD_W'(MAX_HOLD);
    end
    return v + HOLD_W'(1);
  endfunction

  assign elig   = req_i & ~mask_i;
  // While granted, grant_q is exactly onehot(owner), so this is "someone else is waiting".
  assign others = elig & ~grant_q;

  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!win_vld && elig[scan_idx]) begin
        win_vld = 1'b1;
        win_id  = scan_idx;
      end
    end
  end

  assign win_next      = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
  assign owner_gone    = !req_i[id_q] || mask_i[id_q];
  assign owner_expired = (hold_q == HOLD_W'(MAX_HOLD)) && !lock_i[id_q] && (|others);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        id_d    = '0;
        hold_d  = '0;
        if (enable_i && win_vld) begin
          state_d = S_GRANT;
          grant_d = NUM_REQ'(1) << win_id;
          id_d    = win_id;
          hold_d  = HOLD_W'(1);
          ptr_d   = win_next;
        end
      end
      S_GRANT: begin
        // Release outranks pre-emption; both go through one dead IDLE cycle.
        if (owner_gone) begin
          state_d = S_IDLE;
          grant_d = '0;
          id_d    = '0;
          hold_d  = '0;
        end else if (owner_expired) begin
          state_d   = S_IDLE;
          grant_d   = '0;
          id_d      = '0;
          hold_d    = '0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_sat_inc(hold_q);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        id_d    = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      id_q      <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o    = grant_q;
  assign grant_id_o = id_q;
  assign busy_o     = (state_q == S_GRANT);
  assign timeout_o  = timeout_q;

`ifndef SYNTHESIS
  a_grant_onehot0: assert property (@(posedge clk_i) $onehot0(grant_q));
  a_id_matches:    assert property (@(posedge clk_i) (grant_q == '0) || grant_q[id_q]);
  a_busy_matches:  assert property (@(posedge clk_i) busy_o == (|grant_q));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences
// and sticky random stimulus against a cycle-level reference model.
module tb_mem_port_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] lock = '0;
  logic [N-1:0] mask = '0;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: owner index or -1 when nobody holds the port.
  int m_owner = -1;
  int m_hold  = 0;
  int m_ptr   = 0;
  bit m_to    = 1'b0;

  typedef struct packed {
    logic       rn;
    logic       en;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] mask;
    logic [3:0] g;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t tbl[$];

  mem_port_arbiter #(.NUM_REQ(N), .ID_W(2), .MAX_HOLD(MAXH)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .enable_i   (en),
    .req_i      (req),
    .lock_i     (lock),
    .mask_i     (mask),
    .grant_o    (grant),
    .grant_id_o (grant_id),
    .busy_o     (busy),
    .timeout_o  (timeout)
  );

  initial forever #5 clk = ~clk;

  function automatic vec_t mk(input logic rn, input logic e, input logic [3:0] r,
                              input logic [3:0] l, input logic [3:0] m, input logic [3:0] g,
                              input logic [1:0] id, input logic b, input logic t);
    vec_t v;
    v.rn = rn; v.en = e; v.req = r; v.lock = l; v.mask = m;
    v.g = g; v.id = id; v.busy = b; v.to = t;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rn, input logic e_in, input logic [3:0] r,
                            input logic [3:0] l, input logic [3:0] m);
    logic [3:0] elig;
    bit found;
    int g;
    elig = r & ~m;
    if (!rn) begin
      m_owner = -1; m_hold = 0; m_ptr = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      if (e_in && elig != 0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && elig[(m_ptr + k) % N]) begin
            found = 1'b1;
            m_owner = (m_ptr + k) % N;
          end
        end
        m_hold = 1;
        m_ptr  = (m_owner + 1) % N;
      end
    end else begin
      g = m_owner;
      if (!r[g] || m[g]) begin
        m_owner = -1; m_hold = 0; m_to = 1'b0;
      end else if (m_hold == MAXH && !l[g] && (elig & ~(4'b0001 << g)) != 0) begin
        m_owner = -1; m_hold = 0; m_to = 1'b1;
      end else begin
        if (m_hold < MAXH) m_hold++;
        m_to = 1'b0;
      end
    end
  endtask

  // Drive one cycle, advance the model, then compare all outputs #1 after the edge.
  task automatic apply(input logic rn, input logic e_in, input logic [3:0] r,
                       input logic [3:0] l, input logic [3:0] m);
    logic [3:0] eg;
    rst_n = rn; en = e_in; req = r; lock = l; mask = m;
    @(posedge clk);
    model_step(rn, e_in, r, l, m);
    #1;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    chk("model_grant",   32'(grant),    32'(eg));
    chk("model_id",      32'(grant_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk("model_busy",    32'(busy),     32'(m_owner >= 0));
    chk("model_timeout", 32'(timeout),  32'(m_to));
  endtask

  task automatic expect_out(input string nm, input logic [3:0] g, input logic t);
    chk({nm, "_grant"},   32'(grant),   32'(g));
    chk({nm, "_timeout"}, 32'(timeout), 32'(t));
  endtask

  logic [3:0] rq, lk, mk_r;
  logic       rn_r, en_r;

  initial begin
    // Reset, full round-robin lap, reset, then enable/mask behaviour.
    tbl.push_back(mk(0,1,4'hF,0,0, 4'h0,0,0,0));
    tbl.push_back(mk(0,1,4'hF,0,0, 4'h0,0,0,0));
    tbl.push_back(mk(1,1,4'hF,0,0, 4'h1,0,1,0));
    tbl.push_back(mk(1,1,4'hF,0,0, 4'h1,0,1,0));
    tbl.push_back(mk(1,1,4'hF,0,0, 4'h1,0,1,0));
    tbl.push_back(mk(1,1,4'hE,0,0, 4'h0,0,0,0));
    tbl.push_back(mk(1,1,4'hF,0,0, 4'h2,1,1,0));
    tbl.push_back(mk(1,1,4'hF,0,0, 4'h2,1,1,0));
    tbl.push_back(mk(1,1,4'hF,0,0, 4'h2,1,1,0));
    tbl.push_back(mk(1,1,4'hD,0,0, 4'h0,0,0,0));
    tbl.push_back(mk(1,1,4'hF,0,0, 4'h4,2,1,0));
    tbl.push_back(mk(1,1,4'hF,0,0, 4'h4,2,1,0));
    tbl.push_back(mk(1,1,4'hF,0,0, 4'h4,2,1,0));
    tbl.push_back(mk(1,1,4'hB,0,0, 4'h0,0,0,0));
    tbl.push_back(mk(1,1,4'hF,0,0, 4'h8,3,1,0));
    tbl.push_back(mk(1,1,4'hF,0,0, 4'h8,3,1,0));
    tbl.push_back(mk(1,1,4'hF,0,0, 4'h8,3,1,0));
    tbl.push_back(mk(1,1,4'h7,0,0, 4'h0,0,0,0));
    tbl.push_back(mk(1,1,4'hF,0,0, 4'h1,0,1,0));
    tbl.push_back(mk(0,1,4'hF,0,0, 4'h0,0,0,0));
    tbl.push_back(mk(1,0,4'h4,0,0, 4'h0,0,0,0));
    tbl.push_back(mk(1,0,4'h4,0,0, 4'h0,0,0,0));
    tbl.push_back(mk(1,1,4'h4,0,0, 4'h4,2,1,0));
    tbl.push_back(mk(1,1,4'h4,0,0, 4'h4,2,1,0));
    tbl.push_back(mk(1,1,4'h4,0,4'h4, 4'h0,0,0,0));
    tbl.push_back(mk(1,1,4'h4,0,4'h4, 4'h0,0,0,0));
    tbl.push_back(mk(1,1,4'h0,0,0, 4'h0,0,0,0));
    // Enable low mid-tenure must not revoke the grant.
    tbl.push_back(mk(1,1,4'h2,0,0, 4'h2,1,1,0));
    tbl.push_back(mk(1,0,4'h2,0,0, 4'h2,1,1,0));
    tbl.push_back(mk(1,0,4'h0,0,0, 4'h0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rn, tbl[i].en, tbl[i].req, tbl[i].lock, tbl[i].mask);
      chk($sformatf("tbl%0d_grant", i), 32'(grant),    32'(tbl[i].g));
      chk($sformatf("tbl%0d_id", i),    32'(grant_id), 32'(tbl[i].id));
      chk($sformatf("tbl%0d_busy", i),  32'(busy),     32'(tbl[i].busy));
      chk($sformatf("tbl%0d_to", i),    32'(timeout),  32'(tbl[i].to));
    end

    // Pre-emption after MAX_HOLD cycles of unlocked tenure.
    apply(0, 1, 4'h3, 0, 0);
    for (int i = 0; i < MAXH; i++) begin
      apply(1, 1, 4'h3, 0, 0);
      expect_out($sformatf("pre_hold%0d", i), 4'h1, 1'b0);
    end
    apply(1, 1, 4'h3, 0, 0);
    expect_out("pre_cut", 4'h0, 1'b1);
    apply(1, 1, 4'h3, 0, 0);
    expect_out("pre_next", 4'h2, 1'b0);

    // Locked owner outlives MAX_HOLD; unlocking pre-empts at the next edge.
    apply(0, 1, 4'h3, 0, 0);
    for (int i = 0; i < 20; i++) begin
      apply(1, 1, 4'h3, 4'h1, 0);
      expect_out($sformatf("lock_hold%0d", i), 4'h1, 1'b0);
    end
    apply(1, 1, 4'h3, 4'h0, 0);
    expect_out("lock_cut", 4'h0, 1'b1);
    apply(1, 1, 4'h3, 4'h0, 0);
    expect_out("lock_next", 4'h2, 1'b0);

    // Reset mid-grant with requester 1 at HoldCnt=5; pointer must return to 0.
    apply(0, 1, 4'h0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(1, 1, 4'h2, 0, 0);
      expect_out($sformatf("rst_hold%0d", i), 4'h2, 1'b0);
    end
    apply(0, 1, 4'hF, 0, 0);
    expect_out("rst_mid", 4'h0, 1'b0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_id", 32'(grant_id), 32'd0);
    apply(1, 1, 4'hF, 0, 0);
    expect_out("rst_after", 4'h1, 1'b0);

    // Sticky random traffic so tenures run long enough to reach pre-emption.
    rq = 4'hF; lk = 4'h0; mk_r = 4'h0;
    for (int i = 0; i < 4000; i++) begin
      rq   = rq ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      lk   = lk ^ (4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom));
      mk_r = ($urandom_range(0, 15) == 0) ? 4'($urandom) & 4'($urandom) : mk_r;
      rn_r = ($urandom_range(0, 99) != 0);
      en_r = ($urandom_range(0, 9) != 0);
      apply(rn_r, en_r, rq, lk, mk_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares the single data-memory port of the RISC-V core between up to NUM_REQ requesters: CPU load/store, instruction refill, DMA and debug.
- Issues a registered one-hot grant and bounds each tenure with a hold counter. Owners can extend tenure with a lock.
- A per-requester mask and a global enable let software or the debug unit configure who may win.
- Sits between the requesters and the memory address/data mux, and drives that mux's select.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the encoded grant id; must satisfy 2**ID_W >= NUM_REQ.
- MAX_HOLD, 8, cycles after which an unlocked owner is pre-empted if another requester is pending (1..15).

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- Enable  in  1  global arbitration enable.
- Req  in  NUM_REQ  request per requester, level-held until served.
- Lock  in  NUM_REQ  owner asks not to be pre-empted; only the current owner's bit is used.
- Mask  in  NUM_REQ  1 = requester excluded from arbitration.
- Grant  out  NUM_REQ  one-hot grant, registered.
- GrantId  out  ID_W  encoded index of the owner; 0 when idle.
- Busy  out  1  high while in GRANT.
- Timeout  out  1  one-cycle pulse when an owner is pre-empted.

Behaviour:
- Reset (Reset_n=0 at an edge): state=IDLE, Grant=0, GrantId=0, Busy=0, Timeout=0, Ptr=0, HoldCnt=0. Reset wins over every other condition, including mid-grant.
- Eligible vector: E = Req & ~Mask.
- IDLE
  - Enable=1 and E!=0: winner = first set bit of E searching Ptr, Ptr+1, ... cyclically modulo NUM_REQ.
  - At the next edge: Grant=onehot(winner), GrantId=winner, state=GRANT, HoldCnt=1, Ptr=(winner+1) mod NUM_REQ.
  - Latency: Req sampled high at edge k gives Grant high after edge k.
  - Enable=0 or E=0: stay IDLE; all outputs 0.
- GRANT, owner g, evaluated in priority order each edge:
  - Release: Req[g]=0 or Mask[g]=1. Grant=0, state=IDLE, no Timeout. This costs one dead turnaround cycle, so two owners are never granted on consecutive cycles.
  - Pre-empt: HoldCnt==MAX_HOLD and Lock[g]=0 and (E & ~onehot(g))!=0. Grant=0, state=IDLE, Timeout=1 for exactly one cycle.
  - Otherwise: hold the grant; HoldCnt = min(HoldCnt+1, MAX_HOLD), saturating.
- Enable=0 during GRANT does not revoke the current grant. It only blocks new grants in IDLE.
- A locked owner at HoldCnt=MAX_HOLD keeps the grant indefinitely. When Lock drops with others pending, the owner is pre-empted at the next edge.
- At most one Grant bit is high at any time. GrantId always matches Grant.
- Ptr is advanced only on grant issue. This guarantees every continuously requesting, unmasked requester is granted within NUM_REQ tenures.
- Mask or Req changes take effect at the next edge; no combinational path from inputs to outputs.
- Busy = (state==GRANT), registered together with Grant.

Test Plan:
- Reset then idle: hold Reset_n=0 for 2 cycles with Req=4'b1111. After release, Grant, GrantId, Busy and Timeout are all 0 during reset. First Grant=4'b0001 one edge after reset deasserts.
- Round-robin: Req=4'b1111 held, each owner drops Req for one cycle after 3 cycles of tenure. Grant sequence is 0001, 0010, 0100, 1000, 0001, with exactly one Grant=0 cycle between owners.
- Pre-emption: Req=4'b0011 held, Lock=0, MAX_HOLD=8. Requester 0 keeps Grant for 8 cycles, then Grant=0 and Timeout=1 for one cycle. The following cycle Grant=4'b0010.
- Lock: same as above but Lock[0]=1 for 20 cycles. No Timeout; Grant=0001 for 20+ cycles. After Lock[0] falls, the next edge gives Grant=0 with Timeout=1, then Grant=0010.
- Mask and enable: Enable=0 with Req=0100 gives Grant=0 throughout. Raise Enable: Grant=0100 one edge later. Set Mask[2]=1 mid-tenure: the grant releases next edge with no Timeout, then Grant stays 0.
- Reset mid-grant: pull Reset_n=0 while Grant=0010 and HoldCnt=5. Next edge gives all outputs 0 and Ptr=0. After release with Req=1111, Grant=0001.
